// File: rtl/pong_game_ctrl_if.sv
// Handshake bundle between the pong game-flow controller and its surroundings:
// frame/start/score inputs in, restart/clear/ball-enable/status outputs out.
interface pong_game_ctrl_if;
  logic       frame_tick_i;
  logic       start_i;
  logic [3:0] point1_i;
  logic [3:0] point2_i;
  logic       restart_o;
  logic       game_clear_o;
  logic       ball_en_o;
  logic [1:0] winner_o;
  logic [1:0] state_o;

  modport slave (
    input  frame_tick_i, start_i, point1_i, point2_i,
    output restart_o, game_clear_o, ball_en_o, winner_o, state_o
  );

  modport master (
    output frame_tick_i, start_i, point1_i, point2_i,
    input  restart_o, game_clear_o, ball_en_o, winner_o, state_o
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: idle -> serve delay -> play -> game over,
// with delays counted in video frames and scoring taken from the ball block.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a fresh start press; winner of last game shown
// S_SERVE | ball frozen for SERVE_FRAMES frames before it is released
// S_PLAY  | ball moving; any score increment ends the rally
// S_OVER  | game decided; held for OVER_FRAMES frames, then back to idle
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_dly_q;
  logic             armed_q;
  logic [3:0]       prev1_q, prev2_q;
  logic             restart_q, restart_d;
  logic             clear_q, clear_d;
  logic             ball_en_q;
  logic [1:0]       winner_q, winner_d;

  logic start_rise;
  logic inc1, inc2;
  logic win1, win2;

  // armed_q blocks a start level that was already high coming out of reset
  // from being taken as a press; a low must be seen first.
  assign start_rise = bus.start_i & ~start_dly_q & armed_q;

  assign inc1 = (bus.point1_i > prev1_q);
  assign inc2 = (bus.point2_i > prev2_q);
  assign win1 = inc1 & (bus.point1_i >= WIN_PTS);
  assign win2 = inc2 & (bus.point2_i >= WIN_PTS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    clear_d   = 1'b0;
    winner_d  = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          restart_d = 1'b1;
          clear_d   = 1'b1;
          winner_d  = 2'b00;
          cnt_d     = '0;
          state_d   = S_SERVE;
        end
      end

      S_SERVE: begin
        if (bus.frame_tick_i) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PLAY: begin
        // A score increment overrides any coincident frame tick.
        if (inc1 | inc2) begin
          cnt_d = '0;
          if (win1 | win2) begin
            winner_d = {win2, win1};
            state_d  = S_OVER;
          end else begin
            restart_d = 1'b1;
            state_d   = S_SERVE;
          end
        end
      end

      S_OVER: begin
        if (bus.frame_tick_i) begin
          if (cnt_q == OVER_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_dly_q <= 1'b0;
      armed_q     <= 1'b0;
      prev1_q     <= 4'd0;
      prev2_q     <= 4'd0;
      restart_q   <= 1'b0;
      clear_q     <= 1'b0;
      ball_en_q   <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_dly_q <= bus.start_i;
      armed_q     <= armed_q | ~bus.start_i;
      prev1_q     <= bus.point1_i;
      prev2_q     <= bus.point2_i;
      restart_q   <= restart_d;
      clear_q     <= clear_d;
      ball_en_q   <= (state_d == S_PLAY);
      winner_q    <= winner_d;
    end
  end

  assign bus.restart_o    = restart_q;
  assign bus.game_clear_o = clear_q;
  assign bus.ball_en_o    = ball_en_q;
  assign bus.winner_o     = winner_q;
  assign bus.state_o      = state_q;

endmodule
